hc595_shifter: RTL and testbench

//   Serializer that drives a cascade of 74HC595 shift registers for the static LED/word display.

---
 rtl/hc595_shifter.sv | 129 ++++++++++++
 tb/tb_hc595_shifter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_shifter.sv
// Serializer for a cascade of 74HC595 shift registers: one frame per valid/ready handshake, shifted on ds/shcp, latched by stcp.
// Optional HC595_BRIGHTNESS_EN adds a brightness[3:0] input and PWM dimming on oe.
module hc595_shifter #(
    parameter int WIDTH     = 16,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
`ifdef HC595_BRIGHTNESS_EN
    input  logic [3:0]       brightness,
`endif
    input  logic             valid,
    output logic             ready,
    output logic             shcp,
    output logic             stcp,
    output logic             ds,
    output logic             oe
);

    // state | meaning
    // IDLE  | ready=1, waiting for a frame
    // SHIFT | presenting bit k on ds, shcp low then high for CLK_DIV cycles each
    // LATCH | stcp high for CLK_DIV cycles, then back to IDLE
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam int BIT_W = $clog2(WIDTH);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             latched;
    logic             div_done;
    logic             latch_done;
    logic             show;
`ifdef HC595_BRIGHTNESS_EN
    logic [3:0]       pwm_cnt;
`endif

    always_comb begin
        div_done   = (div_cnt == DIV_W'(CLK_DIV - 1));
        latch_done = (state == LATCH) && div_done;
        // the display is enabled from the cycle the first stcp pulse ends
        show       = latched || latch_done;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            latched <= 1'b0;
            ready   <= 1'b1;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            ds      <= 1'b0;
            oe      <= 1'b1;
`ifdef HC595_BRIGHTNESS_EN
            pwm_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        state   <= SHIFT;
                        ready   <= 1'b0;
                        sreg    <= data_in;
                        ds      <= MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
                        shcp    <= 1'b0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (!shcp) begin
                            shcp <= 1'b1;
                        end else if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                            state <= LATCH;
                            shcp  <= 1'b0;
                            stcp  <= 1'b1;
                            ds    <= 1'b0;
                        end else begin
                            shcp    <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            ds      <= MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
                            sreg    <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                                 : {1'b0, sreg[WIDTH-1:1]};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                        stcp    <= 1'b0;
                        ready   <= 1'b1;
                        latched <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready   <= 1'b1;
                    shcp    <= 1'b0;
                    stcp    <= 1'b0;
                    ds      <= 1'b0;
                    div_cnt <= '0;
                end
            endcase

`ifdef HC595_BRIGHTNESS_EN
            pwm_cnt <= pwm_cnt + 1'b1;
            oe      <= show ? ~(pwm_cnt < brightness) : 1'b1;
`else
            oe      <= ~show;
`endif
        end
    end

endmodule

// File: tb/tb_hc595_shifter.sv
// Randomized self-checking bench for hc595_shifter; frames are rebuilt from ds sampled at each shcp rise.
module tb_hc595_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, valid1 = 1'b0;
    logic [15:0] data_in = '0, data1 = '0;
    logic        ready, shcp, stcp, ds, oe;
    logic        ready1, shcp1, stcp1, ds1, oe1;
`ifdef HC595_BRIGHTNESS_EN
    logic [3:0]  brightness = 4'd15;
`endif

    int n_cmp = 0, n_err = 0, cyc = 0;
    bit bits[$], bits1[$];
    int stcp_n = 0, stcp_rise = 0, stcp_fall = 0;
    logic p_shcp = 1'b0, p_stcp = 1'b0, p_ds = 1'b0, p_shcp1 = 1'b0;

    hc595_shifter #(.WIDTH(16), .CLK_DIV(2), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .data_in(data_in),
`ifdef HC595_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .valid(valid), .ready(ready), .shcp(shcp), .stcp(stcp), .ds(ds), .oe(oe));

    hc595_shifter #(.WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .data_in(data1),
`ifdef HC595_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .valid(valid1), .ready(ready1), .shcp(shcp1), .stcp(stcp1), .ds(ds1), .oe(oe1));

    always #5 clk = ~clk;

    // Reference: the k-th bit to leave the chain under the given ordering.
    function automatic bit model_bit(input logic [15:0] d, input int k, input bit msb);
        return msb ? d[15-k] : d[k];
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (shcp && !p_shcp) begin
            bits.push_back(ds);
            n_cmp++;
            if (ds !== p_ds) begin
                n_err++;
                $display("FAIL ds_stable cyc=%0d got=%b required=%b", cyc, ds, p_ds);
            end
        end
        if (stcp && !p_stcp) begin stcp_n++; stcp_rise = cyc; end
        if (!stcp && p_stcp) stcp_fall = cyc;
        if (shcp1 && !p_shcp1) bits1.push_back(ds1);
        p_shcp = shcp; p_stcp = stcp; p_ds = ds; p_shcp1 = shcp1;
    endtask

    task automatic send(input logic [15:0] d, output int hs);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin tick(); n++; end
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_timeout got ready=%b required=1", ready);
        end
        data_in = d; valid = 1'b1; hs = cyc;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin tick(); n++; end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_timeout got ready=%b required=1", ready);
        end
    endtask

    task automatic test_reset();
        valid = 1'b1; data_in = 16'hFFFF;
        repeat (5) tick();
        n_cmp += 5;
        if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b required=1", ready); end
        if (shcp !== 1'b0)  begin n_err++; $display("FAIL rst_shcp got=%b required=0", shcp); end
        if (stcp !== 1'b0)  begin n_err++; $display("FAIL rst_stcp got=%b required=0", stcp); end
        if (ds !== 1'b0)    begin n_err++; $display("FAIL rst_ds got=%b required=0", ds); end
        if (oe !== 1'b1)    begin n_err++; $display("FAIL rst_oe got=%b required=1", oe); end
        valid = 1'b0;
        rst = 1'b1;
        bits.delete();
        repeat (3) tick();
        n_cmp += 2;
        if (bits.size() != 0) begin n_err++; $display("FAIL rst_no_accept got=%0d rises required=0", bits.size()); end
        if (ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b required=1", ready); end
    endtask

    task automatic test_single();
        int hs, s0;
        logic rdy66, oe66;
        bits.delete(); s0 = stcp_n;
        send(16'hA5C3, hs);
        while (cyc < hs + 67) begin
            tick();
            if (cyc == hs + 66) begin rdy66 = ready; oe66 = oe; end
        end
        n_cmp += 6;
        if (bits.size() != 16) begin n_err++; $display("FAIL single_rises got=%0d required=16", bits.size()); end
        for (int k = 0; k < bits.size() && k < 16; k++) begin
            n_cmp++;
            if (bits[k] !== model_bit(16'hA5C3, k, 1'b1)) begin
                n_err++; $display("FAIL single_bit%0d got=%b required=%b", k, bits[k], model_bit(16'hA5C3, k, 1'b1));
            end
        end
        if (stcp_n - s0 != 1) begin n_err++; $display("FAIL single_stcp_count got=%0d required=1", stcp_n - s0); end
        if (stcp_rise != hs + 65) begin n_err++; $display("FAIL single_stcp_rise got=%0d required=%0d", stcp_rise - hs, 65); end
        if (stcp_fall != hs + 67) begin n_err++; $display("FAIL single_stcp_fall got=%0d required=%0d", stcp_fall - hs, 67); end
        if (rdy66 !== 1'b0) begin n_err++; $display("FAIL single_ready66 got=%b required=0", rdy66); end
        if (ready !== 1'b1) begin n_err++; $display("FAIL single_ready67 got=%b required=1", ready); end
`ifndef HC595_BRIGHTNESS_EN
        n_cmp += 2;
        if (oe66 !== 1'b1) begin n_err++; $display("FAIL single_oe66 got=%b required=1", oe66); end
        if (oe !== 1'b0) begin n_err++; $display("FAIL single_oe67 got=%b required=0", oe); end
`endif
    endtask

    task automatic test_back_to_back();
        int hs, s0;
        logic [15:0] fr [2];
        fr[0] = 16'h0001; fr[1] = 16'h8000;
        bits.delete(); s0 = stcp_n;
        wait_idle();
        data_in = fr[0]; valid = 1'b1; hs = cyc;
        tick();
        data_in = fr[1];
        while (cyc < hs + 67) tick();
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready67 got=%b required=1", ready); end
        tick();
        valid = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept68 got ready=%b required=0", ready); end
        wait_idle();
        n_cmp += 3;
        if (bits.size() != 32) begin n_err++; $display("FAIL b2b_rises got=%0d required=32", bits.size()); end
        for (int k = 0; k < bits.size() && k < 32; k++) begin
            n_cmp++;
            if (bits[k] !== model_bit(fr[k/16], k % 16, 1'b1)) begin
                n_err++; $display("FAIL b2b_bit%0d got=%b required=%b", k, bits[k], model_bit(fr[k/16], k % 16, 1'b1));
            end
        end
        if (stcp_n - s0 != 2) begin n_err++; $display("FAIL b2b_stcp_count got=%0d required=2", stcp_n - s0); end
        if (stcp_rise != hs + 67 + 65) begin n_err++; $display("FAIL b2b_stcp2_rise got=%0d required=%0d", stcp_rise - hs, 132); end
    endtask

    task automatic test_busy_ignore();
        int hs, s0;
        logic [15:0] d;
        d = 16'($urandom);
        bits.delete(); s0 = stcp_n;
        send(d, hs);
        while (cyc < hs + 10) tick();
        data_in = 16'hFFFF; valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_idle();
        repeat (20) tick();
        n_cmp += 3;
        if (bits.size() != 16) begin n_err++; $display("FAIL busy_rises got=%0d required=16", bits.size()); end
        for (int k = 0; k < bits.size() && k < 16; k++) begin
            n_cmp++;
            if (bits[k] !== model_bit(d, k, 1'b1)) begin
                n_err++; $display("FAIL busy_bit%0d got=%b required=%b", k, bits[k], model_bit(d, k, 1'b1));
            end
        end
        if (stcp_n - s0 != 1) begin n_err++; $display("FAIL busy_stcp_count got=%0d required=1", stcp_n - s0); end
        if (ready !== 1'b1) begin n_err++; $display("FAIL busy_no_extra got ready=%b required=1", ready); end
    endtask

    task automatic test_reset_mid();
        int hs, s0;
        logic [15:0] d;
        d = 16'($urandom);
        send(d, hs);
        while (cyc < hs + 20) tick();
        rst = 1'b0;
        #1;
        n_cmp += 5;
        if (ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%b required=1", ready); end
        if (shcp !== 1'b0)  begin n_err++; $display("FAIL mid_shcp got=%b required=0", shcp); end
        if (stcp !== 1'b0)  begin n_err++; $display("FAIL mid_stcp got=%b required=0", stcp); end
        if (ds !== 1'b0)    begin n_err++; $display("FAIL mid_ds got=%b required=0", ds); end
        if (oe !== 1'b1)    begin n_err++; $display("FAIL mid_oe got=%b required=1", oe); end
        s0 = stcp_n;
        repeat (60) tick();
        n_cmp++;
        if (stcp_n != s0) begin n_err++; $display("FAIL mid_no_stcp got=%0d pulses required=0", stcp_n - s0); end
        rst = 1'b1;
        tick();
        d = 16'($urandom);
        bits.delete();
        send(d, hs);
        wait_idle();
        tick();
        n_cmp += 2;
        if (bits.size() != 16) begin n_err++; $display("FAIL mid_after_rises got=%0d required=16", bits.size()); end
        for (int k = 0; k < bits.size() && k < 16; k++) begin
            n_cmp++;
            if (bits[k] !== model_bit(d, k, 1'b1)) begin
                n_err++; $display("FAIL mid_after_bit%0d got=%b required=%b", k, bits[k], model_bit(d, k, 1'b1));
            end
        end
        if (stcp_n - s0 != 1) begin n_err++; $display("FAIL mid_after_stcp got=%0d required=1", stcp_n - s0); end
    endtask

    task automatic test_random();
        int hs;
        logic [15:0] d;
        for (int f = 0; f < 6; f++) begin
            d = 16'($urandom);
            repeat ($urandom_range(0, 5)) tick();
            bits.delete();
            send(d, hs);
            wait_idle();
            n_cmp++;
            if (bits.size() != 16) begin n_err++; $display("FAIL rand%0d_rises got=%0d required=16", f, bits.size()); end
            for (int k = 0; k < bits.size() && k < 16; k++) begin
                n_cmp++;
                if (bits[k] !== model_bit(d, k, 1'b1)) begin
                    n_err++; $display("FAIL rand%0d_bit%0d got=%b required=%b", f, k, bits[k], model_bit(d, k, 1'b1));
                end
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [15:0] fr [2];
        int n;
        fr[0] = 16'h0003; fr[1] = 16'($urandom);
        for (int f = 0; f < 2; f++) begin
            n = 0;
            while (ready1 !== 1'b1 && n < 100) begin tick(); n++; end
            bits1.delete();
            data1 = fr[f]; valid1 = 1'b1;
            tick();
            valid1 = 1'b0;
            n = 0;
            while (ready1 !== 1'b1 && n < 100) begin tick(); n++; end
            n_cmp += 2;
            if (ready1 !== 1'b1) begin n_err++; $display("FAIL lsb%0d_timeout got ready=%b required=1", f, ready1); end
            if (bits1.size() != 16) begin n_err++; $display("FAIL lsb%0d_rises got=%0d required=16", f, bits1.size()); end
            for (int k = 0; k < bits1.size() && k < 16; k++) begin
                n_cmp++;
                if (bits1[k] !== model_bit(fr[f], k, 1'b0)) begin
                    n_err++; $display("FAIL lsb%0d_bit%0d got=%b required=%b", f, k, bits1[k], model_bit(fr[f], k, 1'b0));
                end
            end
        end
    endtask

`ifdef HC595_BRIGHTNESS_EN
    task automatic test_brightness();
        int dark;
        int lit;
        brightness = 4'd4;
        repeat (4) tick();
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (oe === 1'b0) lit++;
        end
        n_cmp++;
        if (lit != 8) begin n_err++; $display("FAIL bright4 got=%0d lit cycles required=8", lit); end
        brightness = 4'd0;
        repeat (4) tick();
        dark = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (oe === 1'b1) dark++;
        end
        n_cmp++;
        if (dark != 32) begin n_err++; $display("FAIL bright0 got=%0d dark cycles required=32", dark); end
        brightness = 4'd15;
    endtask
`endif

    initial begin
        #2 rst = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_lsb_first();
`ifdef HC595_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
